// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-boundary update commit (option: SEG_SCAN_LEADING_ZERO_BLANK_EN)
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GAP      = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   LOAD_DATA,
    input  logic                  LOAD_VALID,
    output logic                  LOAD_READY,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     DIG_N,
    output logic                  FRAME_DONE
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_CNT = CW'(GAP);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // A zero-length gap means a slot starts directly in DRIVE.
    localparam state_t ST_RESET = (GAP > 0) ? ST_BLANK : ST_DRIVE;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    state_t                 state_q, state_d;
    logic [4*DIGITS-1:0]    active_q, active_d;
    logic [4*DIGITS-1:0]    pending_q, pending_d;
    logic                   pending_full_q, pending_full_d;
    logic [6:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      dig_n_q, dig_n_d;
    logic                   frame_done_q, frame_done_d;

    logic                   tick;
    logic                   wrap;
    logic                   accept;
    logic [3:0]             cur_nib;
    logic                   lz_blank;

    // Active-low hex decoder shared by all digits; bit 0 is segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick       = (cnt_q == CNT_MAX);
    assign wrap       = tick && (idx_q == IDX_MAX);
    assign LOAD_READY = !pending_full_q;
    assign accept     = LOAD_VALID && LOAD_READY;

    assign SEG        = seg_q;
    assign DIG_N      = dig_n_q;
    assign FRAME_DONE = frame_done_q;

    // Slot prescaler and digit index; the index advances once per slot.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Slot FSM: blank for the first GAP cycles of a slot, drive for the rest.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_d >= GAP_CNT) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // cnt_d only drops below GAP when the slot wraps on tick.
                if (cnt_d < GAP_CNT) begin
                    state_d = ST_BLANK;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Single-entry pending buffer; it moves into the displayed word only at a frame wrap.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        if (wrap && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = LOAD_DATA;
            pending_full_d = 1'b1;
        end
    end

    // Select the nibble of the displayed word belonging to the current digit.
    always_comb begin
        cur_nib = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib = active_q[4*k +: 4];
            end
        end
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Suppress a non-rightmost digit when it and every digit to its left are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((k >= int'(idx_q)) && (active_q[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        lz_blank = (idx_q != '0) && upper_zero;
    end
`else
    // Every digit is shown, zeros included.
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    // Next registered outputs from the current slot state, digit and displayed word.
    always_comb begin
        seg_d        = 7'h7F;
        dig_n_d      = '1;
        frame_done_d = wrap;
        if ((state_q == ST_DRIVE) && !lz_blank) begin
            dig_n_d = ~(DIGITS'(1) << idx_q);
            seg_d   = hex_to_seg(cur_nib);
        end
    end

    // State and output registers; reset blanks the display and drops any pending word.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            state_q        <= ST_RESET;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            seg_q          <= 7'h7F;
            dig_n_q        <= '1;
            frame_done_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            seg_q          <= seg_d;
            dig_n_q        <= dig_n_d;
            frame_done_q   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed bench with cycle model for seg_scan_ctrl (DIGITS=4, PRESCALE=8, GAP=2)
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int GAP      = 2;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        RST_N;
    logic [15:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        LOAD_READY;
    logic [6:0]  SEG;
    logic [3:0]  DIG_N;
    logic        FRAME_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_cnt;
    int          m_idx;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic        m_full;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;
    logic        m_fd;

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .GAP      (GAP)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RST_N      (RST_N),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .SEG        (SEG),
        .DIG_N      (DIG_N),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit lz_hidden(input int idx, input logic [15:0] act);
        return LZ_EN && (idx > 0) && ((act >> (4 * idx)) == 16'h0);
    endfunction

    task automatic m_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_act  = 16'h0;
        m_pend = 16'h0;
        m_full = 1'b0;
        m_seg  = 7'h7F;
        m_dig  = 4'hF;
        m_fd   = 1'b0;
    endtask

    // Advance the model across one rising edge, then compare DUT against it at the falling edge.
    task automatic step();
        bit tick, wrap, acc;
        if (RST_N) begin
            tick = (m_cnt == PRESCALE - 1);
            wrap = tick && (m_idx == DIGITS - 1);
            if ((m_cnt >= GAP) && !lz_hidden(m_idx, m_act)) begin
                m_dig = ~(4'b0001 << m_idx);
                m_seg = seg_tab[m_act[4*m_idx +: 4]];
            end else begin
                m_dig = 4'hF;
                m_seg = 7'h7F;
            end
            m_fd = wrap;
            acc  = LOAD_VALID && !m_full;
            if (wrap && m_full) begin
                m_act  = m_pend;
                m_full = 1'b0;
            end
            if (acc) begin
                m_pend = LOAD_DATA;
                m_full = 1'b1;
            end
            if (tick) begin
                m_cnt = 0;
                m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_eq("seg", SEG, m_seg);
        check_eq("dig_n", DIG_N, m_dig);
        check_eq("frame_done", FRAME_DONE, m_fd);
        check_eq("ready", LOAD_READY, !m_full);
        check_eq("dig_onehot", ($countones(~DIG_N) <= 1), 1);
    endtask

    task automatic wait_dig(input logic [3:0] v, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while ((DIG_N !== v) && (n < 64));
        check_eq(tag, DIG_N, v);
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((FRAME_DONE !== 1'b1) && (n < 100));
        check_eq("wait_fd", FRAME_DONE, 1'b1);
    endtask

    // Offer a word and hold it until a transfer edge; reports whether READY rose on a FRAME_DONE cycle.
    task automatic load_word(input logic [15:0] d, output bit at_fd);
        bit r;
        int n = 0;
        LOAD_DATA  = d;
        LOAD_VALID = 1'b1;
        at_fd      = 1'b0;
        do begin
            r     = LOAD_READY;
            at_fd = FRAME_DONE;
            step();
            n++;
        end while (!r && (n < 100));
        LOAD_VALID = 1'b0;
        check_eq("load_accepted", r, 1'b1);
        check_eq("ready_after_load", LOAD_READY, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  fd_flag;
        int  hi_seen;

        RST_N      = 1'b0;
        LOAD_DATA  = 16'h0;
        LOAD_VALID = 1'b0;
        m_reset();

        // 1. Reset and first drive after release
        step();
        step();
        check_eq("rst_seg", SEG, 7'h7F);
        check_eq("rst_dig", DIG_N, 4'hF);
        check_eq("rst_ready", LOAD_READY, 1'b1);
        check_eq("rst_fd", FRAME_DONE, 1'b0);
        RST_N = 1'b1;
        step();
        check_eq("rel1_dig", DIG_N, 4'hF);
        step();
        check_eq("rel2_dig", DIG_N, 4'hF);
        step();
        check_eq("rel3_dig", DIG_N, 4'hE);
        check_eq("rel3_seg", SEG, 7'h40);

        // 4. Scan order, gap and frame period
        wait_fd(n);
        wait_fd(n);
        check_eq("frame_period", n, 32);
        for (int i = 0; i < 32; i++) step();

        // 2. Load mid-frame and commit at the wrap
        for (int i = 0; i < 10; i++) step();
        load_word(16'h1A39, fd_flag);
        wait_fd(n);
        check_eq("ready_back", LOAD_READY, 1'b1);
        wait_dig(4'hE, "l_d0");
        check_eq("l_seg0", SEG, 7'h10);
        wait_dig(4'hD, "l_d1");
        check_eq("l_seg1", SEG, 7'h30);
        wait_dig(4'hB, "l_d2");
        check_eq("l_seg2", SEG, 7'h08);
        wait_dig(4'h7, "l_d3");
        check_eq("l_seg3", SEG, 7'h79);

        // 3. Back-pressure: second word waits for the first to commit
        load_word(16'h1111, fd_flag);
        load_word(16'h2222, fd_flag);
        check_eq("bp_accept_at_fd", fd_flag, 1'b1);
        wait_dig(4'hE, "bp_n1_d0");
        check_eq("bp_n1_seg0", SEG, 7'h79);
        wait_dig(4'h7, "bp_n1_d3");
        check_eq("bp_n1_seg3", SEG, 7'h79);
        wait_dig(4'hE, "bp_n2_d0");
        check_eq("bp_n2_seg0", SEG, 7'h24);
        wait_dig(4'h7, "bp_n2_d3");
        check_eq("bp_n2_seg3", SEG, 7'h24);

        // 5. Asynchronous reset with a pending word while digit 2 is driven
        wait_fd(n);
        load_word(16'h4321, fd_flag);
        n = 0;
        while (!((m_idx == 2) && (m_cnt == 4)) && (n < 64)) begin
            step();
            n++;
        end
        check_eq("mr_ready_pre", LOAD_READY, 1'b0);
        check_eq("mr_dig_pre", DIG_N, 4'hB);
        RST_N      = 1'b0;
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'hFFFF;
        #1;
        check_eq("mr_seg", SEG, 7'h7F);
        check_eq("mr_dig", DIG_N, 4'hF);
        check_eq("mr_ready", LOAD_READY, 1'b1);
        check_eq("mr_fd", FRAME_DONE, 1'b0);
        m_reset();
        step();
        step();
        check_eq("mr_ready_held", LOAD_READY, 1'b1);
        LOAD_VALID = 1'b0;
        RST_N      = 1'b1;
        step();
        step();
        step();
        check_eq("mr_rel_dig", DIG_N, 4'hE);
        check_eq("mr_rel_seg", SEG, 7'h40);
        wait_dig(4'h7, "mr_d3");
        check_eq("mr_seg3", SEG, 7'h40);
        check_eq("mr_ready_post", LOAD_READY, 1'b1);

        // 6. Leading zeros
        load_word(16'h0050, fd_flag);
        wait_fd(n);
        wait_dig(4'hE, "lz_d0");
        check_eq("lz_seg0", SEG, 7'h40);
        wait_dig(4'hD, "lz_d1");
        check_eq("lz_seg1", SEG, 7'h12);
        if (LZ_EN) begin
            hi_seen = 0;
            n = 0;
            do begin
                step();
                n++;
                if ((DIG_N == 4'hB) || (DIG_N == 4'h7)) hi_seen++;
            end while ((FRAME_DONE !== 1'b1) && (n < 64));
            check_eq("lz_hi_blank", hi_seen, 0);
        end else begin
            wait_dig(4'hB, "lz_d2");
            check_eq("lz_seg2", SEG, 7'h40);
            wait_dig(4'h7, "lz_d3");
            check_eq("lz_seg3", SEG, 7'h40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
